wire_demo: RTL and testbench
============================

// Module: wire_demo
// PURPOSE
//  Net-level demonstration datapath: two operands pass through continuous-assignment (wire) logic
//  selected by an opcode; the combinational result is exposed directly and also captured in a
//  one-stage output register with status flags. Stand-alone teaching/sanity block, instantiable
//  with all ports unconnected (must elaborate cleanly with defaults).
// PARAMETERS
//  W        8   operand/result width in bits, even, >= 4
// PORTS
//  clk        in   1    single clock, all state on rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    operands/op valid this cycle
//  op         in   3    operation select (encoding below)
//  a          in   W    operand A
//  b          in   W    operand B
//  y_comb     out  W    combinational result (pure wires, no state)
//  y_reg      out  W    registered result
//  carry_reg  out  1    registered carry (ADD) / borrow (SUB), 0 for other ops
//  zero_reg   out  1    registered (y == 0)
//  parity_reg out  1    registered XOR-reduction of y
//  out_valid  out  1    registered in_valid
// BEHAVIOUR
//  - Opcodes: 0 AND, 1 OR, 2 XOR, 3 ADD a+b, 4 SUB a-b, 5 NOT a, 6 PASS a,
//    7 SWAP halves {a[W/2-1:0], a[W-1:W/2]}.
//  - ADD: W+1-bit sum, carry = bit W. SUB: modulo 2^W, borrow = (a < b) unsigned.
//  - y_comb follows a/b/op with zero cycles latency regardless of in_valid.
//  - Register stage: on rising clk with in_valid=1, y_reg/carry_reg/zero_reg/parity_reg load the
//    current result and flags; with in_valid=0 they hold. out_valid <= in_valid every cycle.
//  - Latency in_valid -> out_valid: exactly 1 cycle; back-to-back valids give back-to-back outputs.
//  - Reset (async assert, released synchronously to clk by the environment): y_reg=0, carry_reg=0,
//    zero_reg=1 (consistent with y_reg=0), parity_reg=0, out_valid=0. Reset wins over in_valid.
//    Reset mid-stream discards the pending result; first valid after release takes 1 cycle.
//  - Wrap-around: ADD 0xFF+0x01 (W=8) -> y=0x00, carry=1, zero=1. SUB 0x00-0x01 -> 0xFF, borrow=1.
//  - X/Z on unconnected inputs propagates; no assertion or lockup required in that case.
// STRUCTURE
//  - Package wire_demo_pkg: opcode localparams (OP_AND..OP_SWAP), W default.
//  - Sub-module wire_demo_logic: purely combinational (assign-only) op unit producing y, carry,
//    zero, parity; top instantiates it once and adds the register stage.
// TESTING
//  - Reset: assert rst with in_valid=1 -> all registered outputs at reset values, out_valid=0.
//  - ADD a=0xFF b=0x01 in_valid=1 -> y_comb=0x00 same cycle; next edge y_reg=0x00, carry=1, zero=1.
//  - SUB a=0x00 b=0x01 -> y_reg=0xFF, carry_reg=1, parity_reg=0, zero_reg=0.
//  - XOR a=0xA5 b=0x0F -> y_reg=0xAA, parity_reg=0; SWAP a=0x3C -> y_reg=0xC3.
//  - Hold: load AND 0xF0&0x3C=0x30, then in_valid=0 with new a/b -> y_reg stays 0x30,
//    y_comb tracks new inputs, out_valid=0.
//  - Async reset mid-stream (between edges) -> outputs clear immediately, not at next edge.

Source files
------------

// File: rtl/wire_demo_pkg.sv
// Shared definitions for the wire_demo datapath: default width and opcode encoding.
package wire_demo_pkg;

  // Default operand/result width; must be even and at least 4.
  localparam int W_DEFAULT = 8;

  localparam int OP_W = 3;

  // Opcode encoding for the op input.
  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd5;
  localparam logic [OP_W-1:0] OP_PASS = 3'd6;
  localparam logic [OP_W-1:0] OP_SWAP = 3'd7;

endpackage : wire_demo_pkg

// File: rtl/wire_demo_logic.sv
// Purely combinational op unit: result, carry/borrow, zero and parity built
// from continuous assignments only, with no state.
module wire_demo_logic
  import wire_demo_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [W-1:0]    y,
  output logic            carry,
  output logic            zero,
  output logic            parity
);

  // One extra bit on both arithmetic paths: bit W is the carry for ADD and,
  // because the operands are zero-extended, the unsigned borrow (a < b) for SUB.
  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Result mux over all eight opcodes; the case is complete, so there is no default hole.
  assign y = (op == OP_AND)  ? (a & b)                  :
             (op == OP_OR)   ? (a | b)                  :
             (op == OP_XOR)  ? (a ^ b)                  :
             (op == OP_ADD)  ? sum[W-1:0]               :
             (op == OP_SUB)  ? diff[W-1:0]              :
             (op == OP_NOT)  ? ~a                       :
             (op == OP_PASS) ? a                        :
                               {a[W/2-1:0], a[W-1:W/2]};

  // Carry only means something for the arithmetic ops; logic ops report 0.
  assign carry = (op == OP_ADD) ? sum[W]  :
                 (op == OP_SUB) ? diff[W] :
                                  1'b0;

  assign zero   = ~|y;
  assign parity = ^y;

endmodule : wire_demo_logic

// File: rtl/wire_demo.sv
// Top of the wire_demo datapath: combinational op unit exposed directly on
// y_comb, plus a single register stage capturing result and flags on in_valid.
module wire_demo
  import wire_demo_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [W-1:0]    y_comb,
  output logic [W-1:0]    y_reg,
  output logic            carry_reg,
  output logic            zero_reg,
  output logic            parity_reg,
  output logic            out_valid
);

  logic carry_c;
  logic zero_c;
  logic parity_c;

  wire_demo_logic #(
    .W (W)
  ) u_logic (
    .op     (op),
    .a      (a),
    .b      (b),
    .y      (y_comb),
    .carry  (carry_c),
    .zero   (zero_c),
    .parity (parity_c)
  );

  // Output register: load result and flags on in_valid, hold otherwise; out_valid tracks in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // zero_reg resets to 1 so the flags agree with the cleared y_reg.
      y_reg      <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b1;
      parity_reg <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // independent of statement order or of other always_ff blocks.
      out_valid <= in_valid;
      if (in_valid) begin
        y_reg      <= y_comb;
        carry_reg  <= carry_c;
        zero_reg   <= zero_c;
        parity_reg <= parity_c;
      end
    end
  end

endmodule : wire_demo

// File: tb/tb_wire_demo.sv
// Directed self-checking bench for wire_demo (W=8): reset values, each opcode,
// wrap-around, hold on in_valid=0 and asynchronous reset between edges.
module tb_wire_demo;
  import wire_demo_pkg::*;

  localparam int W = 8;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [OP_W-1:0] op;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [W-1:0]    y_comb;
  logic [W-1:0]    y_reg;
  logic            carry_reg;
  logic            zero_reg;
  logic            parity_reg;
  logic            out_valid;

  int checks = 0;
  int errors = 0;

  wire_demo #(
    .W (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .op         (op),
    .a          (a),
    .b          (b),
    .y_comb     (y_comb),
    .y_reg      (y_reg),
    .carry_reg  (carry_reg),
    .zero_reg   (zero_reg),
    .parity_reg (parity_reg),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive a new input vector just after a falling edge and let it settle.
  task automatic drive(input logic v, input logic [OP_W-1:0] o,
                       input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    in_valid = v;
    op       = o;
    a        = aa;
    b        = bb;
    #1;
  endtask

  // Sample the register stage shortly after the next rising edge.
  task automatic check_regs(input string tag, input logic [W-1:0] ey, input logic ec,
                            input logic ez, input logic ep, input logic ev);
    @(posedge clk);
    #1;
    check({tag, "_y_reg"},      {24'd0, y_reg},      {24'd0, ey});
    check({tag, "_carry_reg"},  {31'd0, carry_reg},  {31'd0, ec});
    check({tag, "_zero_reg"},   {31'd0, zero_reg},   {31'd0, ez});
    check({tag, "_parity_reg"}, {31'd0, parity_reg}, {31'd0, ep});
    check({tag, "_out_valid"},  {31'd0, out_valid},  {31'd0, ev});
  endtask

  initial begin
    // Reset held with in_valid=1 and a live ADD vector: reset must win.
    rst      = 1'b1;
    in_valid = 1'b1;
    op       = OP_ADD;
    a        = 8'hFF;
    b        = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    check("reset_y_comb", {24'd0, y_comb}, 32'h00);
    check("reset_y_reg", {24'd0, y_reg}, 32'h00);
    check("reset_carry", {31'd0, carry_reg}, 32'd0);
    check("reset_zero", {31'd0, zero_reg}, 32'd1);
    check("reset_parity", {31'd0, parity_reg}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);

    // Release reset on a falling edge; the ADD vector is already valid.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("add_wrap_y_comb", {24'd0, y_comb}, 32'h00);
    check_regs("add_wrap", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);

    // Back-to-back valid transactions.
    drive(1'b1, OP_SUB, 8'h00, 8'h01);
    check("sub_wrap_y_comb", {24'd0, y_comb}, 32'hFF);
    check_regs("sub_wrap", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);

    drive(1'b1, OP_XOR, 8'hA5, 8'h0F);
    check_regs("xor", 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(1'b1, OP_SWAP, 8'h3C, 8'h00);
    check_regs("swap", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(1'b1, OP_ADD, 8'h12, 8'h34);
    check_regs("add", 8'h46, 1'b0, 1'b0, 1'b1, 1'b1);

    drive(1'b1, OP_OR, 8'h50, 8'h0A);
    check_regs("or", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(1'b1, OP_NOT, 8'h0F, 8'hAA);
    check_regs("not", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(1'b1, OP_PASS, 8'h81, 8'h55);
    check_regs("pass", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(1'b1, OP_SUB, 8'h80, 8'h01);
    check_regs("sub", 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);

    // Hold: load AND result, then drop in_valid with new operands.
    drive(1'b1, OP_AND, 8'hF0, 8'h3C);
    check_regs("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(1'b0, OP_OR, 8'h01, 8'h02);
    check("hold_y_comb", {24'd0, y_comb}, 32'h03);
    check_regs("hold", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load non-reset flags, then assert reset between edges.
    drive(1'b1, OP_ADD, 8'hC0, 8'h50);
    check_regs("pre_rst_add", 8'h10, 1'b1, 1'b0, 1'b1, 1'b1);

    drive(1'b1, OP_XOR, 8'hFF, 8'h0F);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_y_reg", {24'd0, y_reg}, 32'h00);
    check("async_rst_carry", {31'd0, carry_reg}, 32'd0);
    check("async_rst_zero", {31'd0, zero_reg}, 32'd1);
    check("async_rst_parity", {31'd0, parity_reg}, 32'd0);
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Pending XOR discarded; still cleared after the edge inside reset.
    check_regs("in_rst", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // First valid after release lands one cycle later.
    drive(1'b1, OP_PASS, 8'h5A, 8'h00);
    rst = 1'b0;
    check_regs("post_rst", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(1'b0, OP_AND, 8'h00, 8'h00);
    check_regs("post_rst_idle", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wire_demo
